udp_eeprom_cmd_agent: RTL and testbench

Consumes UDP payload bytes from the A receive socket of the GPSDO UDP top and decodes fixed-format command packets that read or write 64-bit EEPROM records. It drives the EEPROM request/done handshake and writes one reply packet per command into the A send FIFO, honouring the full flag. It sits between the A user interfaces (a_rcv_*, a_snd_*) and the EEPROM controller.

---
 rtl/udp_eeprom_cmd_agent_if.sv | 46 ++++
 rtl/udp_eeprom_cmd_agent.sv | 226 ++++++++++++++++++++++
 tb/tb_udp_eeprom_cmd_agent.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_eeprom_cmd_agent_if.sv
`default_nettype none
// ============================================================================
// Module      : udp_eeprom_cmd_agent_if
// Description : Bundles the UDP A-socket receive/send signals, the EEPROM
//               request/done handshake and the status counters of the
//               UDP EEPROM command agent.
// Revision    : 1.0 - initial release
// ============================================================================
interface udp_eeprom_cmd_agent_if;
  // UDP receive socket (payload bytes)
  logic        rcv_valid;
  logic [7:0]  rcv_dout;
  // UDP send FIFO
  logic        snd_full;
  logic        snd_wr_fifo;
  logic        snd_fifo_last;
  logic [7:0]  snd_fifo_din;
  // EEPROM controller
  logic        eeprom_idle;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [63:0] wr_u64;
  logic        wr_done;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic [63:0] rd_u64;
  logic        rd_done;
  // Status counters
  logic [15:0] cmd_cnt;
  logic [15:0] err_cnt;

  // Agent side
  modport master (
    input  rcv_valid, rcv_dout, snd_full, eeprom_idle, wr_done, rd_u64, rd_done,
    output snd_wr_fifo, snd_fifo_last, snd_fifo_din, wr_req, wr_addr, wr_u64,
           rd_req, rd_addr, cmd_cnt, err_cnt
  );

  // Environment side (UDP top, EEPROM controller)
  modport slave (
    output rcv_valid, rcv_dout, snd_full, eeprom_idle, wr_done, rd_u64, rd_done,
    input  snd_wr_fifo, snd_fifo_last, snd_fifo_din, wr_req, wr_addr, wr_u64,
           rd_req, rd_addr, cmd_cnt, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/udp_eeprom_cmd_agent.sv
`default_nettype none
// ============================================================================
// Module      : udp_eeprom_cmd_agent
// Description : Decodes 12-byte UDP command packets (A5 5A op addr data64),
//               runs EEPROM record reads/writes and returns one 13-byte
//               reply per command into the send FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_eeprom_cmd_agent #(
  parameter int GAP_CYCLES = 64,
  parameter int TMO_CYCLES = 2000000
) (
  input  wire logic               clk_125m_eth,
  input  wire logic               rst_eth,
  udp_eeprom_cmd_agent_if.master  bus
);

  localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int c_TMO_W = $clog2(TMO_CYCLES + 1);
  localparam logic [c_GAP_W-1:0] c_GAP_MAX  = c_GAP_W'(GAP_CYCLES);
  // The timer is 0 in the first waiting cycle, so TMO_CYCLES-1 is the last one
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TMO_CYCLES - 1);

  localparam logic [7:0] c_OP_WRITE = 8'h01;
  localparam logic [7:0] c_OP_READ  = 8'h02;
  localparam logic [7:0] c_OP_PING  = 8'h03;
  localparam logic [7:0] c_ST_OK    = 8'h00;
  localparam logic [7:0] c_ST_TMO   = 8'h01;
  localparam logic [7:0] c_ST_BADOP = 8'h02;

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_COLLECT = 3'd1,
    S_EXEC    = 3'd2,
    S_WAIT    = 3'd3,
    S_REPLY   = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_GAP_W-1:0]  r_gap_cnt;
  logic [c_TMO_W-1:0]  r_timer;
  logic [3:0]          r_idx;
  logic [95:0]         r_pkt;
  logic [7:0]          r_op;
  logic [7:0]          r_addr;
  logic [63:0]         r_data;
  logic                r_wr_req;
  logic [7:0]          r_wr_addr;
  logic [63:0]         r_wr_u64;
  logic                r_rd_req;
  logic [7:0]          r_rd_addr;
  logic [103:0]        r_shift;
  logic                r_snd_valid;
  logic [3:0]          r_ridx;
  logic [15:0]         r_cmd_cnt;
  logic [15:0]         r_err_cnt;

  logic w_gap;
  logic w_tmo;
  logic w_magic_ok;
  logic w_write;

  assign w_gap      = (r_gap_cnt == c_GAP_MAX);
  assign w_tmo      = (r_timer == c_TMO_LAST);
  assign w_magic_ok = (r_pkt[95:80] == 16'hA55A);
  // A reply byte is presented continuously; it is only written while not full
  assign w_write    = r_snd_valid & ~bus.snd_full;

  assign bus.snd_wr_fifo   = w_write;
  assign bus.snd_fifo_last = w_write & (r_ridx == 4'd12);
  assign bus.snd_fifo_din  = r_shift[103:96];
  assign bus.wr_req        = r_wr_req;
  assign bus.wr_addr       = r_wr_addr;
  assign bus.wr_u64        = r_wr_u64;
  assign bus.rd_req        = r_rd_req;
  assign bus.rd_addr       = r_rd_addr;
  assign bus.cmd_cnt       = r_cmd_cnt;
  assign bus.err_cnt       = r_err_cnt;

  // Reply frame: 5A A5 op|80 addr status data[63:0]
  function automatic logic [103:0] f_frame(input logic [7:0] op, input logic [7:0] addr,
                                           input logic [7:0] st, input logic [63:0] d);
    return {8'h5A, 8'hA5, op | 8'h80, addr, st, d};
  endfunction

  // Idle-cycle counter: any received byte restarts the packet-boundary timer
  always_ff @(posedge clk_125m_eth) begin
    if (rst_eth) begin
      r_gap_cnt <= '0;
    end else if (bus.rcv_valid) begin
      r_gap_cnt <= '0;
    end else if (!w_gap) begin
      r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
    end
  end

  // Command FSM: packet collection, EEPROM handshake and reply serialisation
  always_ff @(posedge clk_125m_eth) begin
    if (rst_eth) begin
      r_state     <= S_SYNC;
      r_timer     <= '0;
      r_idx       <= '0;
      r_pkt       <= '0;
      r_op        <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_wr_req    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_u64    <= '0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
      r_shift     <= '0;
      r_snd_valid <= 1'b0;
      r_ridx      <= '0;
      r_cmd_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
      case (r_state)
        S_SYNC: begin
          // Wait for a quiet line so collection starts on a packet boundary
          r_idx <= '0;
          if (w_gap) r_state <= S_COLLECT;
        end

        S_COLLECT: begin
          if (w_gap && (r_idx != 4'd0)) begin
            r_idx <= '0;
            if ((r_idx == 4'd12) && w_magic_ok) begin
              r_op    <= r_pkt[79:72];
              r_addr  <= r_pkt[71:64];
              r_data  <= r_pkt[63:0];
              r_timer <= '0;
              r_state <= S_EXEC;
            end else begin
              r_err_cnt <= r_err_cnt + 16'd1;
            end
          end else if (bus.rcv_valid && (r_idx != 4'd12)) begin
            r_pkt <= {r_pkt[87:0], bus.rcv_dout};
            r_idx <= r_idx + 4'd1;
          end
        end

        S_EXEC: begin
          case (r_op)
            c_OP_WRITE, c_OP_READ: begin
              if (bus.eeprom_idle) begin
                if (r_op == c_OP_WRITE) begin
                  r_wr_req  <= 1'b1;
                  r_wr_addr <= r_addr;
                  r_wr_u64  <= r_data;
                end else begin
                  r_rd_req  <= 1'b1;
                  r_rd_addr <= r_addr;
                end
                r_timer <= '0;
                r_state <= S_WAIT;
              end else if (w_tmo) begin
                // Controller never became idle: report a timeout
                r_shift     <= f_frame(r_op, r_addr, c_ST_TMO, 64'd0);
                r_snd_valid <= 1'b1;
                r_ridx      <= '0;
                r_state     <= S_REPLY;
              end else begin
                r_timer <= r_timer + c_TMO_W'(1);
              end
            end
            c_OP_PING: begin
              r_shift     <= f_frame(r_op, r_addr, c_ST_OK, r_data);
              r_snd_valid <= 1'b1;
              r_ridx      <= '0;
              r_state     <= S_REPLY;
            end
            default: begin
              r_shift     <= f_frame(r_op, r_addr, c_ST_BADOP, 64'd0);
              r_snd_valid <= 1'b1;
              r_ridx      <= '0;
              r_state     <= S_REPLY;
            end
          endcase
        end

        S_WAIT: begin
          r_snd_valid <= 1'b1;
          r_ridx      <= '0;
          if ((r_op == c_OP_WRITE) && bus.wr_done) begin
            r_shift <= f_frame(r_op, r_addr, c_ST_OK, r_wr_u64);
            r_state <= S_REPLY;
          end else if ((r_op == c_OP_READ) && bus.rd_done) begin
            r_shift <= f_frame(r_op, r_addr, c_ST_OK, bus.rd_u64);
            r_state <= S_REPLY;
          end else if (w_tmo) begin
            r_shift <= f_frame(r_op, r_addr, c_ST_TMO, 64'd0);
            r_state <= S_REPLY;
          end else begin
            r_snd_valid <= 1'b0;
            r_timer     <= r_timer + c_TMO_W'(1);
          end
        end

        S_REPLY: begin
          if (!bus.snd_full) begin
            if (r_ridx == 4'd12) begin
              r_snd_valid <= 1'b0;
              r_shift     <= '0;
              r_ridx      <= '0;
              r_wr_addr   <= '0;
              r_wr_u64    <= '0;
              r_rd_addr   <= '0;
              r_cmd_cnt   <= r_cmd_cnt + 16'd1;
              r_state     <= S_SYNC;
            end else begin
              r_shift <= {r_shift[95:0], 8'h00};
              r_ridx  <= r_ridx + 4'd1;
            end
          end
        end

        default: r_state <= S_SYNC;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_eeprom_cmd_agent.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_eeprom_cmd_agent
// Description : Directed self-checking bench for udp_eeprom_cmd_agent.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_eeprom_cmd_agent;

  localparam int c_GAP = 8;
  localparam int c_TMO = 100;

  logic clk;
  logic rst;

  udp_eeprom_cmd_agent_if bus();

  udp_eeprom_cmd_agent #(
    .GAP_CYCLES (c_GAP),
    .TMO_CYCLES (c_TMO)
  ) dut (
    .clk_125m_eth (clk),
    .rst_eth      (rst),
    .bus          (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   wr_req_cnt = 0;
  int   rd_req_cnt = 0;
  int   full_viol  = 0;
  bit   bp_en = 0;
  int   bp_cnt = 0;
  logic [7:0] rq[$];
  bit         lq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Send-FIFO full generator: toggles every 3 cycles while enabled
  always @(negedge clk) begin
    if (bp_en) begin
      bp_cnt = bp_cnt + 1;
      if (bp_cnt % 3 == 0) bus.snd_full = ~bus.snd_full;
    end else begin
      bp_cnt = 0;
      bus.snd_full = 1'b0;
    end
  end

  // Reply and request monitor
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.snd_wr_fifo === 1'b1) begin
        rq.push_back(bus.snd_fifo_din);
        lq.push_back(bus.snd_fifo_last);
        if (bus.snd_full === 1'b1) full_viol++;
      end
      if (bus.wr_req === 1'b1) wr_req_cnt++;
      if (bus.rd_req === 1'b1) rd_req_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [95:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rcv_valid = 1'b1;
      bus.rcv_dout  = p[95 - 8*i -: 8];
    end
    @(negedge clk);
    bus.rcv_valid = 1'b0;
    bus.rcv_dout  = 8'h00;
  endtask

  task automatic wait_wr(input int target, input int budget);
    int n = 0;
    while (wr_req_cnt < target && n < budget) begin @(negedge clk); n++; end
    chk("wr_req_seen", 128'(wr_req_cnt >= target), 128'd1);
  endtask

  task automatic wait_rd(input int target, input int budget);
    int n = 0;
    while (rd_req_cnt < target && n < budget) begin @(negedge clk); n++; end
    chk("rd_req_seen", 128'(rd_req_cnt >= target), 128'd1);
  endtask

  task automatic get_reply(input string tag, input logic [103:0] exp, input int budget);
    logic [103:0] obs;
    logic [12:0]  lm;
    int n = 0;
    obs = '0;
    lm  = '0;
    while (rq.size() < 13 && n < budget) begin @(negedge clk); n++; end
    idle(20);
    chk({tag, "_len"}, 128'(rq.size()), 128'd13);
    for (int i = 0; i < 13; i++) begin
      if (rq.size() > 0) begin
        obs = {obs[95:0], rq.pop_front()};
        lm  = {lm[11:0], lq.pop_front()};
      end
    end
    chk(tag, 128'(obs), 128'(exp));
    chk({tag, "_last"}, 128'(lm), 128'd1);
    rq.delete();
    lq.delete();
  endtask

  initial begin
    int n;
    int lastcnt;
    rst = 1'b1;
    bus.rcv_valid   = 1'b0;
    bus.rcv_dout    = 8'h00;
    bus.eeprom_idle = 1'b1;
    bus.wr_done     = 1'b0;
    bus.rd_done     = 1'b0;
    bus.rd_u64      = 64'd0;
    idle(4);

    // Reset state
    chk("rst_wr_fifo", 128'(bus.snd_wr_fifo), 128'd0);
    chk("rst_wr_req",  128'(bus.wr_req), 128'd0);
    chk("rst_cmd_cnt", 128'(bus.cmd_cnt), 128'd0);
    chk("rst_err_cnt", 128'(bus.err_cnt), 128'd0);
    rst = 1'b0;
    idle(c_GAP + 4);

    // Write command, done after 50 cycles
    send_pkt(96'hA55A01101122334455667788, 12);
    wait_wr(1, 40);
    chk("wr_addr", 128'(bus.wr_addr), 128'h10);
    chk("wr_u64",  128'(bus.wr_u64), 128'h1122334455667788);
    idle(50);
    bus.wr_done = 1'b1;
    idle(1);
    bus.wr_done = 1'b0;
    get_reply("wr_reply", 104'h5AA5811000_1122334455667788, 100);
    chk("wr_cmd_cnt", 128'(bus.cmd_cnt), 128'd1);
    chk("wr_req_once", 128'(wr_req_cnt), 128'd1);

    // Read command
    send_pkt(96'hA55A02070000000000000000, 12);
    wait_rd(1, 40);
    chk("rd_addr", 128'(bus.rd_addr), 128'h07);
    idle(5);
    bus.rd_u64  = 64'hDEADBEEFCAFEF00D;
    bus.rd_done = 1'b1;
    idle(1);
    bus.rd_done = 1'b0;
    bus.rd_u64  = 64'd0;
    get_reply("rd_reply", 104'h5AA5820700_DEADBEEFCAFEF00D, 100);
    chk("rd_cmd_cnt", 128'(bus.cmd_cnt), 128'd2);
    chk("rd_req_once", 128'(rd_req_cnt), 128'd1);

    // Ping under send-FIFO backpressure
    bp_en = 1'b1;
    send_pkt(96'hA55A03330102030405060708, 12);
    get_reply("bp_reply", 104'h5AA5833300_0102030405060708, 300);
    bp_en = 1'b0;
    idle(2);
    chk("bp_full_viol", 128'(full_viol), 128'd0);
    chk("bp_cmd_cnt", 128'(bus.cmd_cnt), 128'd3);

    // Short packet, bad magic, then unknown opcode
    send_pkt(96'hA55A01000000000000000000, 8);
    idle(c_GAP + 4);
    chk("short_err", 128'(bus.err_cnt), 128'd1);
    send_pkt(96'hA50001000000000000000000, 12);
    idle(c_GAP + 4);
    chk("magic_err", 128'(bus.err_cnt), 128'd2);
    send_pkt(96'hA55A0944FFFFFFFFFFFFFFFF, 12);
    get_reply("badop_reply", 104'h5AA5894402_0000000000000000, 100);
    chk("badop_err", 128'(bus.err_cnt), 128'd2);
    chk("badop_cmd_cnt", 128'(bus.cmd_cnt), 128'd4);

    // Write with no done pulse: timeout reply
    send_pkt(96'hA55A012000000000000000AB, 12);
    get_reply("tmo_reply", 104'h5AA5812001_0000000000000000, 300);
    chk("tmo_cmd_cnt", 128'(bus.cmd_cnt), 128'd5);
    chk("tmo_wr_req", 128'(wr_req_cnt), 128'd2);

    // Packet arriving during WAIT is dropped
    send_pkt(96'hA55A0130A1A2A3A4A5A6A7A8, 12);
    wait_wr(3, 40);
    send_pkt(96'hA55A03330000000000000001, 12);
    idle(3);
    bus.wr_done = 1'b1;
    idle(1);
    bus.wr_done = 1'b0;
    get_reply("busy_reply", 104'h5AA5813000_A1A2A3A4A5A6A7A8, 100);
    idle(40);
    chk("busy_no_extra", 128'(rq.size()), 128'd0);
    chk("busy_cmd_cnt", 128'(bus.cmd_cnt), 128'd6);
    chk("busy_err_cnt", 128'(bus.err_cnt), 128'd2);

    // Reset in the middle of a reply
    send_pkt(96'hA55A03550F0E0D0C0B0A0908, 12);
    n = 0;
    while (rq.size() < 5 && n < 40) begin @(negedge clk); n++; end
    chk("mid_reply_started", 128'(rq.size() >= 5), 128'd1);
    rst = 1'b1;
    idle(1);
    chk("rr_wr_fifo", 128'(bus.snd_wr_fifo), 128'd0);
    chk("rr_last", 128'(bus.snd_fifo_last), 128'd0);
    chk("rr_din", 128'(bus.snd_fifo_din), 128'd0);
    chk("rr_cmd_cnt", 128'(bus.cmd_cnt), 128'd0);
    chk("rr_err_cnt", 128'(bus.err_cnt), 128'd0);
    chk("rr_wr_addr", 128'(bus.wr_addr), 128'd0);
    lastcnt = 0;
    foreach (lq[i]) if (lq[i]) lastcnt++;
    chk("rr_no_last_seen", 128'(lastcnt), 128'd0);
    rst = 1'b0;
    rq.delete();
    lq.delete();
    idle(c_GAP + 4);
    send_pkt(96'hA55A03550F0E0D0C0B0A0908, 12);
    get_reply("post_rst_reply", 104'h5AA5835500_0F0E0D0C0B0A0908, 100);
    chk("post_rst_cmd_cnt", 128'(bus.cmd_cnt), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
